// File: rtl/delta_tile_sequencer.sv
// delta_tile_sequencer: walks one convolution layer tile by tile.
// Loop order, innermost to outermost: input-channel tiles, output columns,
// output rows, output-channel tiles. Each tile launches the bias/input/compute
// phases on external engines, and output buffers are flushed after the last
// input-channel tile of each output tile.
//
// Handshakes (both follow request/acknowledge semantics):
//   start/ack  : start is sampled only in IDLE. ack pulses for one cycle when
//                the layer is accepted. The channel counts, size and enables
//                are captured in that same edge, so later changes are ignored.
//   phase_start/phase_done : phase_start pulses in the first cycle of a phase.
//                The matching phase_done bit is honoured only from the second
//                cycle on. A done bit seen in the start cycle is dropped.
module delta_tile_sequencer #(
  parameter int PU_NUM = 4,
  parameter int PU_OC  = 8,
  parameter int IN_CH  = 8,
  parameter int OUT_H  = 8,
  parameter int OUT_W  = 8,
  parameter int CH_W   = 10,
  parameter int SZ_W   = 8
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  output logic                                   ack,
  output logic                                   done,
  output logic                                   busy,
  input  logic [CH_W-1:0]                        ic_num,
  input  logic [CH_W-1:0]                        oc_num,
  input  logic [SZ_W-1:0]                        orc_size,
  input  logic                                   load_input,
  input  logic                                   store_output,
  output logic [5:0]                             phase_start,
  input  logic [5:0]                             phase_done,
  output logic                                   finish_cycle,
  output logic [1:0]                             dram_sel,
  output logic [$clog2(IN_CH):0]                 pu_ic_num,
  output logic [PU_NUM*($clog2(PU_OC)+1)-1:0]    pu_oc_num,
  output logic [PU_NUM-1:0]                      pu_active,
  output logic [CH_W-1:0]                        tile_i_ch,
  output logic [CH_W-1:0]                        tile_o_ch,
  output logic [SZ_W-1:0]                        tile_o_r,
  output logic [SZ_W-1:0]                        tile_o_c,
  output logic [$clog2((OUT_H > OUT_W) ? OUT_H : OUT_W):0] tile_rows,
  output logic [$clog2((OUT_H > OUT_W) ? OUT_H : OUT_W):0] tile_cols,
  output logic [3:0]                             dbg_state_o
);

  localparam int PIW = $clog2(IN_CH) + 1;
  localparam int POW = $clog2(PU_OC) + 1;
  localparam int DW  = $clog2((OUT_H > OUT_W) ? OUT_H : OUT_W) + 1;
  localparam int EW  = CH_W + 8;  // headroom for tile_o_ch + p*PU_OC

  localparam int PH_INLD = 0;
  localparam int PH_BIAS = 1;
  localparam int PH_IBUF = 2;
  localparam int PH_COMP = 3;
  localparam int PH_OBUF = 4;
  localparam int PH_OST  = 5;

  // The encoding is visible on dbg_state_o; IDLE is 0.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_ACK = 4'd1, S_INLD = 4'd2, S_CHECK = 4'd3,
    S_BIAS = 4'd4, S_IBUF = 4'd5, S_COMP = 4'd6, S_FIN = 4'd7,
    S_OBUF = 4'd8, S_ADV = 4'd9, S_OST = 4'd10, S_DONE = 4'd11
  } state_t;

  state_t          state_q, state_d;
  logic            first_q;
  logic [CH_W-1:0] ic_q, oc_q;
  logic [SZ_W-1:0] orc_q;
  logic            load_q, store_q;
  logic [CH_W-1:0] tile_i_ch_q, tile_o_ch_q;
  logic [SZ_W-1:0] tile_o_r_q, tile_o_c_q;
  logic            last_q;

  // Candidate next index per loop level and whether that level wraps.
  logic [CH_W:0] ich_nxt, och_nxt;
  logic [SZ_W:0] or_nxt, oc_nxt;
  logic          ich_last, och_last, or_last, col_last, all_done;

  assign ich_nxt  = {1'b0, tile_i_ch_q} + (CH_W+1)'(IN_CH);
  assign och_nxt  = {1'b0, tile_o_ch_q} + (CH_W+1)'(PU_NUM * PU_OC);
  assign or_nxt   = {1'b0, tile_o_r_q} + (SZ_W+1)'(OUT_H);
  assign oc_nxt   = {1'b0, tile_o_c_q} + (SZ_W+1)'(OUT_W);
  assign ich_last = ich_nxt >= {1'b0, ic_q};
  assign och_last = och_nxt >= {1'b0, oc_q};
  assign or_last  = or_nxt >= {1'b0, orc_q};
  assign col_last = oc_nxt >= {1'b0, orc_q};
  assign all_done = last_q || (ic_q == '0) || (oc_q == '0) || (orc_q == '0);

  // State register; first_q marks the first cycle spent in a newly entered state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
    end
  end

  // Next-state decode and phase_start pulses (from registered state only).
  always_comb begin
    state_d     = state_q;
    phase_start = 6'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ACK;
      S_ACK:   state_d = load_q ? S_INLD : S_CHECK;
      S_INLD: begin
        phase_start[PH_INLD] = first_q;
        if (!first_q && phase_done[PH_INLD]) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (all_done) state_d = store_q ? S_OST : S_DONE;
        else          state_d = (tile_i_ch_q == '0) ? S_BIAS : S_IBUF;
      end
      S_BIAS: begin
        phase_start[PH_BIAS] = first_q;
        if (!first_q && phase_done[PH_BIAS]) state_d = S_IBUF;
      end
      S_IBUF: begin
        phase_start[PH_IBUF] = first_q;
        if (!first_q && phase_done[PH_IBUF]) state_d = S_COMP;
      end
      S_COMP: begin
        phase_start[PH_COMP] = first_q;
        if (!first_q && phase_done[PH_COMP]) state_d = S_FIN;
      end
      S_FIN:   state_d = ich_last ? S_OBUF : S_ADV;
      S_OBUF: begin
        phase_start[PH_OBUF] = first_q;
        if (!first_q && phase_done[PH_OBUF]) state_d = S_ADV;
      end
      S_ADV:   state_d = S_CHECK;
      S_OST: begin
        phase_start[PH_OST] = first_q;
        if (!first_q && phase_done[PH_OST]) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Layer configuration capture and tile index walk.
  always_ff @(posedge clock) begin
    if (reset) begin
      ic_q        <= '0;
      oc_q        <= '0;
      orc_q       <= '0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      tile_i_ch_q <= '0;
      tile_o_ch_q <= '0;
      tile_o_r_q  <= '0;
      tile_o_c_q  <= '0;
      last_q      <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        ic_q    <= ic_num;
        oc_q    <= oc_num;
        orc_q   <= orc_size;
        load_q  <= load_input;
        store_q <= store_output;
      end
      if (state_q == S_ADV) begin
        if (!ich_last) tile_i_ch_q <= ich_nxt[CH_W-1:0];
        else begin
          tile_i_ch_q <= '0;
          if (!col_last) tile_o_c_q <= oc_nxt[SZ_W-1:0];
          else begin
            tile_o_c_q <= '0;
            if (!or_last) tile_o_r_q <= or_nxt[SZ_W-1:0];
            else begin
              tile_o_r_q <= '0;
              if (!och_last) tile_o_ch_q <= och_nxt[CH_W-1:0];
              else begin
                tile_o_ch_q <= '0;
                last_q      <= 1'b1;
              end
            end
          end
        end
      end
      if (state_q == S_DONE) begin
        tile_i_ch_q <= '0;
        tile_o_ch_q <= '0;
        tile_o_r_q  <= '0;
        tile_o_c_q  <= '0;
        last_q      <= 1'b0;
      end
    end
  end

  // Per-tile extents: clamped remainders, never underflowing below zero.
  always_comb begin
    logic [CH_W-1:0] ic_rem;
    logic [SZ_W-1:0] r_rem, c_rem;
    logic [EW-1:0]   oc_base, oc_ext, oc_rem;
    ic_rem    = ic_q - tile_i_ch_q;
    r_rem     = orc_q - tile_o_r_q;
    c_rem     = orc_q - tile_o_c_q;
    oc_ext    = {8'b0, oc_q};
    oc_base   = '0;
    oc_rem    = '0;
    pu_ic_num = '0;
    pu_oc_num = '0;
    pu_active = '0;
    tile_rows = '0;
    tile_cols = '0;
    if (ic_q > tile_i_ch_q)
      pu_ic_num = (ic_rem >= CH_W'(IN_CH)) ? PIW'(IN_CH) : ic_rem[PIW-1:0];
    if (orc_q > tile_o_r_q)
      tile_rows = (r_rem >= SZ_W'(OUT_H)) ? DW'(OUT_H) : r_rem[DW-1:0];
    if (orc_q > tile_o_c_q)
      tile_cols = (c_rem >= SZ_W'(OUT_W)) ? DW'(OUT_W) : c_rem[DW-1:0];
    for (int p = 0; p < PU_NUM; p++) begin
      oc_base = {8'b0, tile_o_ch_q} + EW'(p * PU_OC);
      if (oc_ext > oc_base) begin
        oc_rem = oc_ext - oc_base;
        pu_oc_num[p*POW +: POW] = (oc_rem >= EW'(PU_OC)) ? POW'(PU_OC) : oc_rem[POW-1:0];
        pu_active[p] = 1'b1;
      end
    end
  end

  // DRAM owner decoded from the current state.
  always_comb begin
    dram_sel = 2'd0;
    case (state_q)
      S_OBUF, S_OST: dram_sel = 2'd1;
      S_BIAS:        dram_sel = 2'd2;
      S_COMP, S_FIN: dram_sel = 2'd3;
      default:       dram_sel = 2'd0;
    endcase
  end

  assign ack          = (state_q == S_ACK);
  assign done         = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign finish_cycle = (state_q == S_FIN);
  assign tile_i_ch    = tile_i_ch_q;
  assign tile_o_ch    = tile_o_ch_q;
  assign tile_o_r     = tile_o_r_q;
  assign tile_o_c     = tile_o_c_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_delta_tile_sequencer.sv
// Bench for delta_tile_sequencer: a phase-engine responder answers every
// phase_start after a random delay, a monitor records each phase launch with
// the tile extents, and a loop-nest model of the layer predicts the launches.
module tb_delta_tile_sequencer;
  localparam int PU_NUM = 4;
  localparam int PU_OC  = 8;
  localparam int IN_CH  = 8;
  localparam int OUT_H  = 8;
  localparam int OUT_W  = 8;
  localparam int CH_W   = 10;
  localparam int SZ_W   = 8;
  localparam int PIW    = 4;
  localparam int POW    = 4;
  localparam int DW     = 4;
  localparam int RW     = 3 + 2 + PIW + PU_NUM*POW + PU_NUM + DW + DW;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic                   start = 1'b0;
  logic                   ack, done, busy, finish_cycle;
  logic [CH_W-1:0]        ic_num = '0, oc_num = '0;
  logic [SZ_W-1:0]        orc_size = '0;
  logic                   load_input = 1'b0, store_output = 1'b0;
  logic [5:0]             phase_start;
  logic [5:0]             phase_done = '0;
  logic [1:0]             dram_sel;
  logic [PIW-1:0]         pu_ic_num;
  logic [PU_NUM*POW-1:0]  pu_oc_num;
  logic [PU_NUM-1:0]      pu_active;
  logic [CH_W-1:0]        tile_i_ch, tile_o_ch;
  logic [SZ_W-1:0]        tile_o_r, tile_o_c;
  logic [DW-1:0]          tile_rows, tile_cols;
  logic [3:0]             dbg_state_o;

  delta_tile_sequencer #(
    .PU_NUM(PU_NUM), .PU_OC(PU_OC), .IN_CH(IN_CH), .OUT_H(OUT_H),
    .OUT_W(OUT_W), .CH_W(CH_W), .SZ_W(SZ_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .ack(ack), .done(done),
    .busy(busy), .ic_num(ic_num), .oc_num(oc_num), .orc_size(orc_size),
    .load_input(load_input), .store_output(store_output),
    .phase_start(phase_start), .phase_done(phase_done),
    .finish_cycle(finish_cycle), .dram_sel(dram_sel), .pu_ic_num(pu_ic_num),
    .pu_oc_num(pu_oc_num), .pu_active(pu_active), .tile_i_ch(tile_i_ch),
    .tile_o_ch(tile_o_ch), .tile_o_r(tile_o_r), .tile_o_c(tile_o_c),
    .tile_rows(tile_rows), .tile_cols(tile_cols), .dbg_state_o(dbg_state_o)
  );

  // scoreboard state
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] obs_q[$];
  int checks = 0;
  int errors = 0;
  int ack_cnt = 0, done_cnt = 0, fin_cnt = 0, b2b_cnt = 0, multi_cnt = 0, busy_bad = 0;
  int cyc = 0, ack_cyc = 0, done_cyc = 0;
  logic [5:0] prev_ps = '0;
  bit hold_mode = 1'b0;
  bit spam = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] dram_of(input int ph);
    case (ph)
      1:       return 2'd2;
      3:       return 2'd3;
      4, 5:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [RW-1:0] pack_rec(input int ph, input logic [1:0] dr,
      input logic [PIW-1:0] pic, input logic [PU_NUM*POW-1:0] poc,
      input logic [PU_NUM-1:0] act, input logic [DW-1:0] rows, input logic [DW-1:0] cols);
    return {3'(ph), dr, pic, poc, act, rows, cols};
  endfunction

  // phase-engine responder: answers each launch 1..4 cycles later
  int resp_cnt = 0;
  logic [5:0] resp_bits = '0;
  always @(negedge clock) begin
    if (reset) begin
      resp_cnt = 0;
      resp_bits = '0;
      phase_done = '0;
    end else begin
      phase_done = '0;
      if (phase_start != 0) begin
        resp_bits = phase_start;
        resp_cnt = $urandom_range(1, 4);
        if (hold_mode) phase_done = 6'h3F;
      end else if (resp_bits != 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          phase_done = resp_bits;
          resp_bits = '0;
        end
      end
    end
  end

  // monitor: records phase launches and pulse counts
  always @(negedge clock) begin
    int idx;
    cyc++;
    if (!reset) begin
      if (phase_start != 0) begin
        if ($countones(phase_start) != 1) multi_cnt++;
        if (prev_ps != 0) b2b_cnt++;
        if (!busy) busy_bad++;
        idx = 0;
        for (int b = 0; b < 6; b++) if (phase_start[b]) idx = b;
        if (idx == 0 || idx == 5)
          obs_q.push_back(pack_rec(idx, dram_sel, '0, '0, '0, '0, '0));
        else
          obs_q.push_back(pack_rec(idx, dram_sel, pu_ic_num, pu_oc_num, pu_active, tile_rows, tile_cols));
      end
      if (ack) begin ack_cnt++; ack_cyc = cyc; if (!busy) busy_bad++; end
      if (done) begin done_cnt++; done_cyc = cyc; if (!busy) busy_bad++; end
      if (finish_cycle) fin_cnt++;
    end
    prev_ps = phase_start;
  end

  task automatic check_zero(input string pre);
    check({pre, "_ack"}, ack, 0);
    check({pre, "_done"}, done, 0);
    check({pre, "_busy"}, busy, 0);
    check({pre, "_phase_start"}, phase_start, 0);
    check({pre, "_finish"}, finish_cycle, 0);
    check({pre, "_dram_sel"}, dram_sel, 0);
    check({pre, "_pu_active"}, pu_active, 0);
    check({pre, "_pu_oc_num"}, pu_oc_num, 0);
    check({pre, "_pu_ic_num"}, pu_ic_num, 0);
    check({pre, "_tile_i_ch"}, tile_i_ch, 0);
    check({pre, "_tile_o_ch"}, tile_o_ch, 0);
    check({pre, "_tile_o_r"}, tile_o_r, 0);
    check({pre, "_tile_o_c"}, tile_o_c, 0);
    check({pre, "_tile_rows"}, tile_rows, 0);
    check({pre, "_tile_cols"}, tile_cols, 0);
    check({pre, "_state_idle"}, dbg_state_o, 0);
  endtask

  // driver + model for one layer; entered and left just after a posedge
  task automatic run_layer(input int ic, input int oc, input int orc, input bit ld, input bit st,
      input int want_comp, input int want_bias, input int want_obuf, input int max_lat);
    int ncomp, n, rem, c_comp, c_bias, c_obuf, lim;
    logic [PIW-1:0] pic;
    logic [PU_NUM*POW-1:0] poc;
    logic [PU_NUM-1:0] act;
    logic [DW-1:0] rows, cols;
    exp_q.delete();
    ncomp = 0;
    if (ld) exp_q.push_back(pack_rec(0, dram_of(0), '0, '0, '0, '0, '0));
    if (ic > 0 && oc > 0 && orc > 0)
      for (int och = 0; och < oc; och += PU_NUM*PU_OC)
        for (int r = 0; r < orc; r += OUT_H)
          for (int c = 0; c < orc; c += OUT_W)
            for (int i = 0; i < ic; i += IN_CH) begin
              pic = PIW'((ic - i < IN_CH) ? ic - i : IN_CH);
              poc = '0;
              act = '0;
              for (int p = 0; p < PU_NUM; p++) begin
                rem = oc - och - p*PU_OC;
                if (rem > PU_OC) rem = PU_OC;
                if (rem < 0) rem = 0;
                poc[p*POW +: POW] = POW'(rem);
                act[p] = (rem > 0);
              end
              rows = DW'((orc - r < OUT_H) ? orc - r : OUT_H);
              cols = DW'((orc - c < OUT_W) ? orc - c : OUT_W);
              if (i == 0) exp_q.push_back(pack_rec(1, dram_of(1), pic, poc, act, rows, cols));
              exp_q.push_back(pack_rec(2, dram_of(2), pic, poc, act, rows, cols));
              exp_q.push_back(pack_rec(3, dram_of(3), pic, poc, act, rows, cols));
              ncomp++;
              if (i + IN_CH >= ic) exp_q.push_back(pack_rec(4, dram_of(4), pic, poc, act, rows, cols));
            end
    if (st) exp_q.push_back(pack_rec(5, dram_of(5), '0, '0, '0, '0, '0));

    obs_q.delete();
    ack_cnt = 0; done_cnt = 0; fin_cnt = 0; b2b_cnt = 0; multi_cnt = 0; busy_bad = 0;
    ic_num = CH_W'(ic); oc_num = CH_W'(oc); orc_size = SZ_W'(orc);
    load_input = ld; store_output = st; start = 1'b1;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!ack && n < 20);
    check("ack_seen", ack, 1);
    start = 1'b0;
    ic_num = CH_W'($urandom); oc_num = CH_W'($urandom); orc_size = SZ_W'($urandom);
    load_input = $urandom_range(0, 1); store_output = $urandom_range(0, 1);
    n = 0;
    while (!done && n < 20000) begin
      start = spam && ($urandom_range(0, 7) == 0);
      @(posedge clock); #1; n++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    repeat (3) @(posedge clock);
    #1;
    check("ack_count", ack_cnt, 1);
    check("done_count", done_cnt, 1);
    check("finish_count", fin_cnt, ncomp);
    check("back_to_back_starts", b2b_cnt, 0);
    check("onehot_starts", multi_cnt, 0);
    check("busy_coverage", busy_bad, 0);
    check("idle_busy", busy, 0);
    check("idle_dram_sel", dram_sel, 0);
    check("phase_count", obs_q.size(), exp_q.size());
    lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < lim; k++) check("phase_rec", obs_q[k], exp_q[k]);
    c_comp = 0; c_bias = 0; c_obuf = 0;
    foreach (obs_q[k]) begin
      if (obs_q[k][RW-1 -: 3] == 3'd3) c_comp++;
      if (obs_q[k][RW-1 -: 3] == 3'd1) c_bias++;
      if (obs_q[k][RW-1 -: 3] == 3'd4) c_obuf++;
    end
    if (want_comp >= 0) check("comp_count", c_comp, want_comp);
    if (want_bias >= 0) check("bias_count", c_bias, want_bias);
    if (want_obuf >= 0) check("obuf_count", c_obuf, want_obuf);
    if (max_lat > 0) check("ack_to_done_bound", (done_cyc - ack_cyc) <= max_lat, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // single tile, full PUs, load and store
    run_layer(8, 32, 8, 1, 1, 1, 1, 1, 0);
    // partial IC and OC tiles
    run_layer(20, 40, 8, 0, 0, 6, 2, 2, 0);
    // partial spatial tiles
    run_layer(8, 8, 12, 0, 1, 4, 4, 4, 0);
    // empty layer
    run_layer(8, 0, 8, 0, 0, 0, 0, 0, 3);

    // reset in the middle of a compute phase
    obs_q.delete();
    ic_num = 10'd8; oc_num = 10'd32; orc_size = 8'd8;
    load_input = 1'b1; store_output = 1'b1; start = 1'b1;
    n = 0;
    do begin @(posedge clock); #1; n++; start = 1'b0; end while (!phase_start[3] && n < 2000);
    check("reached_comp", phase_start[3], 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_zero("midrst");
    reset = 1'b0;
    run_layer(8, 32, 8, 1, 1, 1, 1, 1, 0);

    // done held through start cycles, start pulsed while busy
    hold_mode = 1'b1;
    spam = 1'b1;
    run_layer(8, 32, 8, 1, 1, 1, 1, 1, 0);
    run_layer(20, 40, 8, 1, 1, 6, 2, 2, 0);
    hold_mode = 1'b0;

    // random layers
    for (int t = 0; t < 6; t++) begin
      spam = $urandom_range(0, 1);
      run_layer($urandom_range(1, 24), $urandom_range(1, 70), $urandom_range(1, 17),
                $urandom_range(0, 1), $urandom_range(0, 1), -1, -1, -1, 0);
    end
    run_layer(0, $urandom_range(1, 70), $urandom_range(1, 17), 1, 1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/delta_tile_sequencer.md
DELTA_TILE_SEQUENCER -- requirements
Module: delta_tile_sequencer

Interface
REQ-001 Parameter PU_NUM, default 4, number of processing units.
REQ-002 Parameter PU_OC, default 8, output channels per PU per tile.
REQ-003 Parameter IN_CH, default 8, input channels per tile.
REQ-004 Parameter OUT_H, default 8, output tile rows; OUT_W, default 8, output tile columns.
REQ-005 Parameter CH_W, default 10, channel-count width; SZ_W, default 8, feature-size width.
REQ-006 clock  in  1  clock; all logic on posedge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 start  in  1  layer request; ack out 1 one-cycle accept pulse; done out 1 one-cycle completion pulse; busy out 1 high from ACK through DONE.
REQ-009 ic_num, oc_num  in  CH_W  layer channel counts; orc_size in SZ_W  square output feature size.
REQ-010 load_input, store_output  in  1  enable initial input-SRAM load / final output-SRAM store.
REQ-011 phase_start  out  6  one-cycle pulses, bits {5:OST, 4:OBUF, 3:COMP, 2:IBUF, 1:BIAS, 0:INLD}; phase_done in 6, same order.
REQ-012 finish_cycle  out  1  one-cycle pulse after each compute phase.
REQ-013 dram_sel  out  2  DRAM owner: 0 input, 1 output, 2 bias, 3 weight.
REQ-014 pu_ic_num  out  clog2(IN_CH)+1; pu_oc_num out PU_NUM*(clog2(PU_OC)+1), PU p in slice p; pu_active out PU_NUM.
REQ-015 tile_i_ch, tile_o_ch  out  CH_W; tile_o_r, tile_o_c out SZ_W; tile_rows, tile_cols out clog2(max(OUT_H,OUT_W))+1.

Function
REQ-016 States: IDLE, ACK, INLD, CHECK, BIAS, IBUF, COMP, FIN, OBUF, ADV, OST, DONE.
REQ-017 IDLE->ACK on start; ACK pulses ack, latches ic_num/oc_num/orc_size/load_input/store_output; input changes after ACK are ignored.
REQ-018 ACK->INLD if load_input, else CHECK.
REQ-019 Phase states (INLD, BIAS, IBUF, COMP, OBUF, OST) pulse their phase_start bit in the first cycle only; matching phase_done accepted from the second cycle onward; done in the start cycle is ignored.
REQ-020 INLD->CHECK; BIAS->IBUF; IBUF->COMP; COMP->FIN; OST->DONE, each on accepted done.
REQ-021 CHECK: all tiles complete (or any latched count zero) -> OST if store_output else DONE; otherwise BIAS if tile_i_ch==0 else IBUF.
REQ-022 FIN (1 cycle, pulses finish_cycle) -> OBUF if current IC tile is last, else ADV; OBUF -> ADV on done.
REQ-023 ADV (1 cycle): loop order innermost to outermost i_ch (+IN_CH), o_c (+OUT_W), o_r (+OUT_H), o_ch (+PU_NUM*PU_OC); each wraps to 0 when reaching ceil-rounded bound and carries outward; -> CHECK.
REQ-024 Tile counts use ceiling division; partial last tiles are processed, never dropped.
REQ-025 pu_ic_num = min(IN_CH, ic - tile_i_ch).
REQ-026 pu_oc_num[p] = clamp(oc - tile_o_ch - p*PU_OC, 0, PU_OC), signed-safe, no underflow; pu_active[p] = (pu_oc_num[p] != 0).
REQ-027 tile_rows = min(OUT_H, orc - tile_o_r); tile_cols = min(OUT_W, orc - tile_o_c).
REQ-028 dram_sel: INLD/IBUF 0, OBUF/OST 1, BIAS 2, COMP/FIN 3, all other states 0.
REQ-029 DONE pulses done, clears indices, -> IDLE; start while busy is ignored.
REQ-030 All outputs are registered or decoded from registered state; no combinational path phase_done->phase_start.

Reset
REQ-031 reset forces IDLE from any state including mid-phase; next cycle ack, done, busy, phase_start, finish_cycle, dram_sel, pu_active = 0; indices and latched config = 0.
REQ-032 No phase_start pulse is issued in the cycle reset deasserts; a start in the first post-reset cycle is accepted normally.

Verification
REQ-033 ic=8, oc=32, orc=8, load=store=1 -> phase order INLD,BIAS,IBUF,COMP,OBUF,OST; pu_oc_num all 8; pu_active=4'b1111; one done.
REQ-034 ic=20, oc=40, orc=8 -> pu_ic_num 8,8,4 per output tile; second o_ch tile pu_oc_num {8,0,0,0}, pu_active=4'b0001; COMP x6, BIAS x2, OBUF x2.
REQ-035 ic=8, oc=8, orc=12 -> 4 spatial tiles; (tile_rows, tile_cols) = (8,8),(8,4),(4,8),(4,4); OBUF x4.
REQ-036 oc=0, store=0 -> ack then done within 3 cycles, no phase_start pulse.
REQ-037 reset asserted during COMP -> next cycle all outputs 0, state IDLE; new start runs REQ-033 correctly.
REQ-038 phase_done held high through phase_start cycle and start pulsed while busy -> both ignored; sequence unchanged.
